switch_gesture_decoder: RTL and testbench

Input front end for the memory game. It takes the four raw push-button inputs, synchronises and debounces each one, and reports clean debounced levels. It also classifies each complete press-and-release gesture as a single-switch press, the SW1+SW2 start combo, or a discarded multi-press. It sits between the board pins and the game state machine, so the game sees at most one event pulse per gesture.

---
 rtl/gesture_pkg.sv | 34 +++
 rtl/switch_debounce.sv | 64 ++++++
 rtl/switch_gesture_decoder.sv | 123 ++++++++++++
 tb/tb_switch_gesture_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// ---------------------------------------------------------------------------
// gesture_pkg
// Shared definitions for the switch gesture decoder: the gesture FSM state
// encoding, the switch count, the SW1+SW2 start-combo mask, and two helpers
// for classifying the accumulated gesture mask.
// ---------------------------------------------------------------------------
package gesture_pkg;

    localparam int         SWITCH_COUNT = 4;
    localparam logic [3:0] START_MASK   = 4'b0011;

    typedef enum logic {
        GESTURE_IDLE = 1'b0,
        GESTURE_HELD = 1'b1
    } gesture_state_e;

    // True when exactly one bit of the mask is set.
    function automatic logic is_one_hot(input logic [3:0] mask);
        return (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
    endfunction

    // Index of the set bit of a one-hot mask; 0 for anything else.
    function automatic logic [1:0] one_hot_index(input logic [3:0] mask);
        logic [1:0] idx;
        case (mask)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
// One push-button channel: a 2-flop synchroniser followed by a stability
// counter. The debounced level only follows the synchronised input after it
// has disagreed with the level for DEBOUNCE_LIMIT consecutive cycles; any
// return to the current level restarts the count from zero.
//
// Ports:
//   i_Clk     system clock
//   i_Rst     synchronous active-high reset
//   i_Switch  raw asynchronous switch pin, 1 = pressed
//   o_Switch  registered debounced level
// ---------------------------------------------------------------------------
module switch_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int             CW         = $clog2(DEBOUNCE_LIMIT) + 1;
    localparam logic [CW-1:0]  LAST_COUNT = CW'(DEBOUNCE_LIMIT - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          level_q;
    logic          level_d;

    // The counter only runs while the synchronised input disagrees with the
    // level; the level flips on the cycle the count would reach the limit.
    always_comb begin
        count_d = count_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            count_d = '0;
        end else if (count_q == LAST_COUNT) begin
            level_d = sync2_q;
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            count_q <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
            count_q <= count_d;
            level_q <= level_d;
        end
    end

    assign o_Switch = level_q;

endmodule

// File: rtl/switch_gesture_decoder.sv
// ---------------------------------------------------------------------------
// switch_gesture_decoder
// Input front end for the memory game. Debounces the four push buttons and
// classifies each complete press-and-release gesture on release:
//   - exactly one switch involved  -> o_Press_Valid pulse with o_Press_Id
//   - exactly SW1+SW2 involved     -> o_Start pulse
//   - any other multi-switch set   -> o_Discard pulse
// A gesture runs from the first debounced level rising until all debounced
// levels are low again; every switch seen high in between is accumulated.
//
// Ports:
//   i_Clk, i_Rst               clock, synchronous active-high reset
//   i_Switch_1..i_Switch_4     raw switch pins, 1 = pressed
//   o_Switch_1..o_Switch_4     registered debounced levels
//   o_Press_Valid, o_Press_Id  single-switch gesture pulse and its index
//   o_Start                    SW1+SW2 combo gesture pulse
//   o_Discard                  other multi-switch gesture pulse
//   o_Gesture_Held             debug view of the FSM: 1 while in HELD
// ---------------------------------------------------------------------------
module switch_gesture_decoder
    import gesture_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_Switch_1,
    output logic       o_Switch_2,
    output logic       o_Switch_3,
    output logic       o_Switch_4,
    output logic       o_Press_Valid,
    output logic [1:0] o_Press_Id,
    output logic       o_Start,
    output logic       o_Discard,
    output logic       o_Gesture_Held
);

    logic [SWITCH_COUNT-1:0] raw;
    logic [SWITCH_COUNT-1:0] level;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < SWITCH_COUNT; g++) begin : g_debounce
        switch_debounce #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_debounce (
            .i_Clk   (i_Clk),
            .i_Rst   (i_Rst),
            .i_Switch(raw[g]),
            .o_Switch(level[g])
        );
    end

    gesture_state_e          state_q;
    logic [SWITCH_COUNT-1:0] mask_q;
    logic                    press_valid_q;
    logic [1:0]              press_id_q;
    logic                    start_q;
    logic                    discard_q;

    // Event outputs default low every cycle so each one is a single-cycle
    // pulse registered on the edge after the last level falls.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q       <= GESTURE_IDLE;
            mask_q        <= '0;
            press_valid_q <= 1'b0;
            press_id_q    <= 2'd0;
            start_q       <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            press_valid_q <= 1'b0;
            press_id_q    <= 2'd0;
            start_q       <= 1'b0;
            discard_q     <= 1'b0;
            case (state_q)
                GESTURE_IDLE: begin
                    if (|level) begin
                        state_q <= GESTURE_HELD;
                        mask_q  <= level;
                    end
                end
                GESTURE_HELD: begin
                    if (level == '0) begin
                        // Levels are all low here, so mask_q is already the
                        // complete set of switches touched in this gesture.
                        state_q <= GESTURE_IDLE;
                        mask_q  <= '0;
                        if (is_one_hot(mask_q)) begin
                            press_valid_q <= 1'b1;
                            press_id_q    <= one_hot_index(mask_q);
                        end else if (mask_q == START_MASK) begin
                            start_q <= 1'b1;
                        end else begin
                            discard_q <= 1'b1;
                        end
                    end else begin
                        mask_q <= mask_q | level;
                    end
                end
                default: begin
                    state_q <= GESTURE_IDLE;
                    mask_q  <= '0;
                end
            endcase
        end
    end

    assign o_Switch_1     = level[0];
    assign o_Switch_2     = level[1];
    assign o_Switch_3     = level[2];
    assign o_Switch_4     = level[3];
    assign o_Press_Valid  = press_valid_q;
    assign o_Press_Id     = press_id_q;
    assign o_Start        = start_q;
    assign o_Discard      = discard_q;
    assign o_Gesture_Held = (state_q == GESTURE_HELD);

endmodule

// File: tb/tb_switch_gesture_decoder.sv
// ---------------------------------------------------------------------------
// tb_switch_gesture_decoder
// Directed bench for switch_gesture_decoder with DEBOUNCE_LIMIT = 4.
// A table of simple gestures (all switches pressed together, held, released
// together) is applied in a loop; hand-written sequences cover latency,
// glitch rejection, staggered combos, reset mid-gesture and back-to-back
// presses. Expected events are pushed into exp_q and popped by a monitor.
// Event code: {type[1:0], id[1:0]}, type 1 = press, 2 = start, 3 = discard.
// ---------------------------------------------------------------------------
module tb_switch_gesture_decoder;

    localparam int         LIMIT    = 4;
    localparam logic [1:0] EV_PRESS = 2'd1;
    localparam logic [1:0] EV_START = 2'd2;
    localparam logic [1:0] EV_DISC  = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_i = 4'd0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic       o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4;
    logic       o_Press_Valid, o_Start, o_Discard, o_Gesture_Held;
    logic [1:0] o_Press_Id;
    logic [3:0] sw_o;

    assign sw_o = {o_Switch_4, o_Switch_3, o_Switch_2, o_Switch_1};

    switch_gesture_decoder #(
        .DEBOUNCE_LIMIT(LIMIT)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Switch_1    (sw_i[0]),
        .i_Switch_2    (sw_i[1]),
        .i_Switch_3    (sw_i[2]),
        .i_Switch_4    (sw_i[3]),
        .o_Switch_1    (o_Switch_1),
        .o_Switch_2    (o_Switch_2),
        .o_Switch_3    (o_Switch_3),
        .o_Switch_4    (o_Switch_4),
        .o_Press_Valid (o_Press_Valid),
        .o_Press_Id    (o_Press_Id),
        .o_Start       (o_Start),
        .o_Discard     (o_Discard),
        .o_Gesture_Held(o_Gesture_Held)
    );

    // ---------------- scoreboard state ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    int         valid_cyc_q[$];
    int         last_valid_cyc = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- event monitor ----------------
    always @(negedge clk) begin : monitor
        logic [2:0] ev;
        logic [3:0] code;
        logic [3:0] exp_code;
        if (!rst) begin
            if (!o_Press_Valid) check("press_id_idle", int'(o_Press_Id), 0);
            ev = {o_Press_Valid, o_Start, o_Discard};
            if (ev != 3'b000) begin
                check("event_exclusive", $countones(ev), 1);
                if (o_Press_Valid)  code = {EV_PRESS, o_Press_Id};
                else if (o_Start)   code = {EV_START, 2'd0};
                else                code = {EV_DISC, 2'd0};
                if (o_Press_Valid) begin
                    valid_cyc_q.push_back(cyc);
                    last_valid_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got code %0h expected none (cycle %0d)", code, cyc);
                end else begin
                    exp_code = exp_q.pop_front();
                    check("event_code", int'(code), int'(exp_code));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int idx, input logic val, input string name, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sw_o[idx] == val) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got timeout expected level %0d on switch %0d", name, val, idx + 1);
        end
    endtask

    task automatic quiet_and_drain(input string name);
        repeat (20) tick();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] mask;
        int         hold;
        logic [3:0] exp_code;   // 0 = no event expected
    } vec_t;

    vec_t vecs[11];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int k, rise, fall, r, n0;
        logic seen_rise;

        vecs[0]  = '{4'b0001, 10, {EV_PRESS, 2'd0}};
        vecs[1]  = '{4'b0010, 10, {EV_PRESS, 2'd1}};
        vecs[2]  = '{4'b0100, 10, {EV_PRESS, 2'd2}};
        vecs[3]  = '{4'b1000, 10, {EV_PRESS, 2'd3}};
        vecs[4]  = '{4'b0011, 10, {EV_START, 2'd0}};
        vecs[5]  = '{4'b1010, 10, {EV_DISC,  2'd0}};
        vecs[6]  = '{4'b1111, 10, {EV_DISC,  2'd0}};
        vecs[7]  = '{4'b0110, 10, {EV_DISC,  2'd0}};
        vecs[8]  = '{4'b1100, 10, {EV_DISC,  2'd0}};
        vecs[9]  = '{4'b0001,  4, {EV_PRESS, 2'd0}};  // exactly the limit: accepted
        vecs[10] = '{4'b0100,  3, 4'h0};              // one short of the limit: ignored

        // Reset state
        rst  = 1'b1;
        sw_i = 4'd0;
        repeat (3) tick();
        check("reset_levels", int'(sw_o), 0);
        check("reset_press_valid", int'(o_Press_Valid), 0);
        check("reset_press_id", int'(o_Press_Id), 0);
        check("reset_start", int'(o_Start), 0);
        check("reset_discard", int'(o_Discard), 0);
        check("reset_held", int'(o_Gesture_Held), 0);
        rst = 1'b0;
        repeat (2) tick();

        // SW3 held 10 cycles: latency of level rise and of the event
        exp_q.push_back({EV_PRESS, 2'd2});
        sw_i = 4'b0100;
        k = cyc + 1;
        wait_level(2, 1'b1, "sw3_rise", rise);
        check("sw3_rise_latency", rise - k, LIMIT + 1);
        while (cyc < k + 9) tick();
        sw_i = 4'b0000;
        wait_level(2, 1'b0, "sw3_fall", fall);
        repeat (3) tick();
        check("sw3_event_delay", last_valid_cyc - fall, 1);
        quiet_and_drain("sw3_drain");

        // Table-driven simple gestures
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].exp_code != 4'h0) exp_q.push_back(vecs[v].exp_code);
            sw_i = vecs[v].mask;
            repeat (vecs[v].hold) tick();
            if (vecs[v].hold >= LIMIT + 2) begin
                check("vec_level", int'(sw_o), int'(vecs[v].mask));
                check("vec_held", int'(o_Gesture_Held), 1);
            end
            sw_i = 4'b0000;
            quiet_and_drain("vec_drain");
        end

        // Glitching SW1: 3-cycle highs, 1-cycle lows
        seen_rise = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sw_i = 4'b0001;
            for (int j = 0; j < 3; j++) begin
                tick();
                seen_rise = seen_rise | sw_o[0];
            end
            sw_i = 4'b0000;
            tick();
            seen_rise = seen_rise | sw_o[0];
        end
        check("glitch_no_rise", int'(seen_rise), 0);
        quiet_and_drain("glitch_drain");

        // SW1 held, SW2 added later, released on different cycles
        exp_q.push_back({EV_START, 2'd0});
        sw_i = 4'b0001;
        repeat (20) tick();
        sw_i = 4'b0011;
        repeat (10) tick();
        sw_i = 4'b0010;
        repeat (3) tick();
        sw_i = 4'b0000;
        quiet_and_drain("combo_drain");

        // SW2 and SW4 overlapped, released one after the other
        exp_q.push_back({EV_DISC, 2'd0});
        sw_i = 4'b0010;
        repeat (6) tick();
        sw_i = 4'b1010;
        repeat (10) tick();
        sw_i = 4'b1000;
        repeat (5) tick();
        sw_i = 4'b0000;
        quiet_and_drain("discard_drain");

        // Reset mid-gesture with SW1 kept held
        sw_i = 4'b0001;
        wait_level(0, 1'b1, "pre_rst_rise", rise);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_outputs",
              int'({sw_o, o_Press_Valid, o_Press_Id, o_Start, o_Discard, o_Gesture_Held}), 0);
        rst = 1'b0;
        r = cyc;
        exp_q.push_back({EV_PRESS, 2'd0});
        wait_level(0, 1'b1, "post_rst_rise", rise);
        check("rst_rise_latency", rise - (r + 1), LIMIT + 1);
        repeat (3) tick();
        sw_i = 4'b0000;
        quiet_and_drain("rst_drain");

        // Back-to-back SW1 then SW4
        n0 = valid_cyc_q.size();
        exp_q.push_back({EV_PRESS, 2'd0});
        exp_q.push_back({EV_PRESS, 2'd3});
        sw_i = 4'b0001;
        repeat (8) tick();
        sw_i = 4'b0000;
        repeat (8) tick();
        sw_i = 4'b1000;
        repeat (8) tick();
        sw_i = 4'b0000;
        quiet_and_drain("b2b_drain");
        check("b2b_count", valid_cyc_q.size() - n0, 2);
        if (valid_cyc_q.size() - n0 == 2)
            check("b2b_spacing_ok", int'(valid_cyc_q[n0 + 1] - valid_cyc_q[n0] >= LIMIT + 1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
